// File: rtl/cam3.sv
// Associative tag store with registered lookup, auto-allocating writes
// (update-in-place, then free slot, then round-robin victim) and invalidate-by-tag.
module cam3 #(
    parameter int BITS   = 8,
    parameter int TAG_SZ = 8,
    parameter int WORDS  = 8,
    localparam int AW    = $clog2(WORDS),
    localparam int CW    = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [TAG_SZ-1:0] check_tag,
    input  logic              write_,
    input  logic              alloc,
    input  logic [AW-1:0]     w_addr,
    input  logic [BITS-1:0]   wdata,
    input  logic [TAG_SZ-1:0] new_tag,
    input  logic              new_valid,
    input  logic              inv,
    input  logic [TAG_SZ-1:0] inv_tag,
    output logic              rd_valid,
    output logic              found_it,
    output logic [BITS-1:0]   data,
    output logic [AW-1:0]     hit_addr,
    output logic              multi_hit,
    output logic              wr_ack,
    output logic [AW-1:0]     wr_addr,
    output logic [CW-1:0]     count,
    output logic              full
);

    logic [TAG_SZ-1:0] tag_mem  [WORDS];
    logic [BITS-1:0]   data_mem [WORDS];
    logic [WORDS-1:0]  valid_mem;
    logic [AW-1:0]     victim;

    logic              lk_hit, lk_multi;
    logic [AW-1:0]     lk_addr;
    logic [BITS-1:0]   lk_data;
    logic              upd_hit, free_hit;
    logic [AW-1:0]     upd_addr, free_addr, target;
    logic [WORDS-1:0]  next_valid;
    logic [CW-1:0]     next_count;

    // All searches see pre-edge contents; same-cycle inv does not affect target choice.
    always_comb begin
        lk_hit    = 1'b0;
        lk_multi  = 1'b0;
        lk_addr   = '0;
        lk_data   = '0;
        upd_hit   = 1'b0;
        upd_addr  = '0;
        free_hit  = 1'b0;
        free_addr = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (valid_mem[i] && tag_mem[i] == check_tag) begin
                if (lk_hit) begin
                    lk_multi = 1'b1;
                end else begin
                    lk_hit  = 1'b1;
                    lk_addr = AW'(i);
                    lk_data = data_mem[i];
                end
            end
            if (valid_mem[i] && tag_mem[i] == new_tag && !upd_hit) begin
                upd_hit  = 1'b1;
                upd_addr = AW'(i);
            end
            if (!valid_mem[i] && !free_hit) begin
                free_hit  = 1'b1;
                free_addr = AW'(i);
            end
        end

        if (!alloc)        target = w_addr;
        else if (upd_hit)  target = upd_addr;
        else if (free_hit) target = free_addr;
        else               target = victim;

        // Invalidate first, then let the write override its own entry.
        next_valid = valid_mem;
        for (int i = 0; i < WORDS; i++) begin
            if (inv && tag_mem[i] == inv_tag) next_valid[i] = 1'b0;
            if (!write_ && target == AW'(i))  next_valid[i] = new_valid;
        end

        next_count = '0;
        for (int i = 0; i < WORDS; i++) next_count = next_count + CW'(next_valid[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
            valid_mem <= '0;
            victim    <= '0;
            rd_valid  <= 1'b0;
            found_it  <= 1'b0;
            multi_hit <= 1'b0;
            data      <= '0;
            hit_addr  <= '0;
            wr_ack    <= 1'b0;
            wr_addr   <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            valid_mem <= next_valid;
            count     <= next_count;
            full      <= (next_count == CW'(WORDS));
            rd_valid  <= read;
            found_it  <= read && lk_hit;
            multi_hit <= read && lk_multi;
            if (read) begin
                data     <= lk_data;
                hit_addr <= lk_addr;
            end
            wr_ack <= !write_;
            if (!write_) begin
                wr_addr <= target;
                for (int i = 0; i < WORDS; i++) begin
                    if (target == AW'(i)) begin
                        tag_mem[i]  <= new_tag;
                        data_mem[i] <= wdata;
                    end
                end
                if (alloc && !upd_hit && !free_hit)
                    victim <= (victim == AW'(WORDS - 1)) ? '0 : victim + AW'(1);
            end
        end
    end

endmodule

// File: doc/cam3.md
Name: cam3

Overview:
- Parametrised successor to the 8x8 CAM: associative tag store of WORDS entries, each holding TAG_SZ tag, BITS data and a valid bit.
- Adds a registered lookup with hit address and multi-hit flag, and an auto-allocate write with update-in-place and round-robin replacement.
- Adds invalidate-by-tag and an occupancy count/full flag.
- Sits between the requester and the backing store as a small lookup cache.

Parameters:
- BITS, 8, data width per entry.
- TAG_SZ, 8, tag width.
- WORDS, 8, number of entries (>=2; need not be a power of 2).
- AW, $clog2(WORDS), address width (derived; do not override).
- CW, $clog2(WORDS+1), count width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high; one clock, single domain.
- read  in  1  lookup request, active-high.
- check_tag  in  TAG_SZ  lookup tag.
- write_  in  1  write strobe, active-low.
- alloc  in  1  1 = auto-allocate target; 0 = use w_addr.
- w_addr  in  AW  explicit write address (ignored when alloc=1).
- wdata  in  BITS  write data.
- new_tag  in  TAG_SZ  write tag.
- new_valid  in  1  valid bit written with entry.
- inv  in  1  invalidate-by-tag request.
- inv_tag  in  TAG_SZ  tag to invalidate.
- rd_valid  out  1  lookup result valid (registered).
- found_it  out  1  lookup hit (registered).
- data  out  BITS  hit data (registered).
- hit_addr  out  AW  hit entry index (registered).
- multi_hit  out  1  more than one valid entry matched (registered).
- wr_ack  out  1  write performed last cycle (registered pulse).
- wr_addr  out  AW  entry written (registered).
- count  out  CW  number of valid entries.
- full  out  1  count == WORDS.

Behaviour:
- Reset (rst=1 at edge):
  - All tag, data and valid memories cleared to 0.
  - Victim pointer = 0.
  - Every output = 0.
  - Reset mid-operation aborts pending results; nothing else is retained.
- Lookup, one cycle latency:
  - read=1 at edge N compares check_tag against the valid entries as they stood before edge N. A write, alloc or inv in the same cycle is not visible to that lookup.
  - At N+1: rd_valid=1 and found_it=any match.
  - On a hit, hit_addr and data come from the lowest-index match; multi_hit=1 if two or more entries match.
  - On a miss, found_it=0, multi_hit=0, and data/hit_addr = 0.
  - read=0: rd_valid=0, found_it=0, multi_hit=0; data and hit_addr hold their previous values.
- Write (write_=0):
  - alloc=0: entry w_addr gets {new_tag, wdata, new_valid}. new_valid=0 therefore invalidates that entry.
  - alloc=1, target chosen in priority order:
    - (a) lowest-index valid entry whose tag == new_tag (update in place);
    - (b) else the lowest-index invalid entry;
    - (c) else (full) the victim pointer entry, after which the victim pointer advances by 1 and wraps from WORDS-1 to 0.
  - The victim pointer changes only in case (c).
  - Every write gives wr_ack=1 and wr_addr=target at the next cycle; otherwise wr_ack=0 and wr_addr holds.
- Invalidate:
  - inv=1 clears the valid bit of every entry whose tag == inv_tag. Tag and data are untouched.
  - inv combined with a write in the same cycle: the invalidate is applied first, then the write.
  - Allocation target selection uses pre-edge state and ignores a same-cycle inv.
- count/full:
  - Registered; they reflect the state after each edge (one cycle after the causing write/inv).
  - count ranges 0..WORDS. full=1 exactly when count==WORDS.
- Tag compare is an exact TAG_SZ-bit equality. Entries with valid=0 never match (lookup, inv or alloc update).

Test Plan:
- Explicit writes: write_=0, alloc=0, tags 5/6/0/4/9 to addresses 1/3/5/6/7 with data 11/13/15/16/17. Then read tags 5,6,7,0,4,9,1 -> found_it 1,1,0,1,1,1,0; data 11,13,–,15,16,17,–; hit_addr 1,3,–,5,6,7,–; count=5 after the last write.
- Multi-hit: write tag 3 at addr 2 (data AA) and addr 4 (data BB), then read tag 3 -> found_it=1, multi_hit=1, hit_addr=2, data=AA.
- Alloc fill and replacement: after reset, alloc tags 1..8 -> wr_addr 0..7 in order, full=1. Alloc tags 20, 21, 22 -> wr_addr 0, 1, 2. Read tag 1 -> miss; read tag 21 -> hit at 1.
- Alloc update in place: entries full, alloc tag 5 data 77 -> wr_addr = existing index of tag 5, count unchanged, victim pointer unchanged; read 5 -> 77.
- Invalidate: inv_tag=4 with an explicit write to addr 0 in the same cycle -> entry 4's valid cleared, addr 0 written, count decremented by 1 net of addr 0's prior state. Read 4 in the inv cycle -> hit; read 4 in the next cycle -> miss.
- Reset mid-stream: assert rst during a read cycle -> the next cycle shows rd_valid=0, count=0, full=0, and all lookups miss.
